// File: rtl/fib_seq_gen.sv
// Fibonacci term generator with programmable seeds and run length.
// Streams terms over valid/ready and flags values that overflowed WIDTH bits.
module fib_seq_gen #(
    parameter int WIDTH       = 32,
    parameter int IDX_W       = 8,
    parameter int STOP_ON_OVF = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] seed_a,
    input  logic [WIDTH-1:0] seed_b,
    input  logic [IDX_W-1:0] n_terms,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_ovf,
    output logic             busy,
    output logic             done,
    output logic             ovf
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] nxt;
    logic             w_cur;
    logic             w_nxt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] last;
    logic             ovf_q;
    logic [WIDTH:0]   sum;
    logic             w_sum;
    logic             xfer;
    logic             is_last;
    logic             stop_hit;

    assign sum      = {1'b0, cur} + {1'b0, nxt};
    assign w_sum    = sum[WIDTH] | w_cur | w_nxt;
    assign xfer     = (state == RUN) && out_ready;
    assign is_last  = (idx == last);
    // In stop mode the run ends instead of ever presenting a flagged term
    assign stop_hit = (STOP_ON_OVF != 0) && w_nxt;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (n_terms == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (xfer && (is_last || stop_hit)) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cur   <= '0;
            nxt   <= '0;
            w_cur <= 1'b0;
            w_nxt <= 1'b0;
            idx   <= '0;
            last  <= '0;
            ovf_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                cur   <= seed_a;
                nxt   <= seed_b;
                w_cur <= 1'b0;
                w_nxt <= 1'b0;
                idx   <= '0;
                last  <= n_terms - 1'b1;
                ovf_q <= 1'b0;
            end else if (xfer && !is_last) begin
                if (w_nxt) begin
                    ovf_q <= 1'b1;
                end
                if (!stop_hit) begin
                    cur   <= nxt;
                    nxt   <= sum[WIDTH-1:0];
                    w_cur <= w_nxt;
                    w_nxt <= w_sum;
                    idx   <= idx + 1'b1;
                end
            end
        end
    end

    assign out_valid = (state == RUN);
    assign out_data  = cur;
    assign out_idx   = idx;
    assign out_ovf   = out_valid & w_cur;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_fib_seq_gen.sv
// Scoreboard bench for fib_seq_gen: one 32-bit wrap instance and
// two 8-bit instances (wrap and stop-on-overflow).
module tb_fib_seq_gen;

    typedef struct packed {
        logic [31:0] d;
        logic [7:0]  i;
        logic        o;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  st = '0;
    logic [31:0] sa = '0;
    logic [31:0] sb = '0;
    logic [7:0]  nt = '0;
    logic        rdy = 1'b1;
    logic        rnd_en = 1'b0;

    logic        v32, o32, b32, dn32, f32;
    logic [31:0] d32;
    logic [7:0]  i32;
    logic        vw, ow, bw, dnw, fw;
    logic [7:0]  dw, iw;
    logic        vs, os, bs, dns, fs;
    logic [7:0]  ds, is_;

    logic [2:0]  vl, dn, bz, ov;
    assign vl = {vs, vw, v32};
    assign dn = {dns, dnw, dn32};
    assign bz = {bs, bw, b32};
    assign ov = {fs, fw, f32};

    exp_t q32[$];
    exp_t qw[$];
    exp_t qs[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fib_seq_gen #(.WIDTH(32), .IDX_W(8), .STOP_ON_OVF(0)) u32 (
        .clk(clk), .rst(rst), .start(st[0]),
        .seed_a(sa), .seed_b(sb), .n_terms(nt),
        .out_ready(rdy), .out_valid(v32), .out_data(d32),
        .out_idx(i32), .out_ovf(o32), .busy(b32),
        .done(dn32), .ovf(f32)
    );

    fib_seq_gen #(.WIDTH(8), .IDX_W(8), .STOP_ON_OVF(0)) u8w (
        .clk(clk), .rst(rst), .start(st[1]),
        .seed_a(sa[7:0]), .seed_b(sb[7:0]), .n_terms(nt),
        .out_ready(rdy), .out_valid(vw), .out_data(dw),
        .out_idx(iw), .out_ovf(ow), .busy(bw),
        .done(dnw), .ovf(fw)
    );

    fib_seq_gen #(.WIDTH(8), .IDX_W(8), .STOP_ON_OVF(1)) u8s (
        .clk(clk), .rst(rst), .start(st[2]),
        .seed_a(sa[7:0]), .seed_b(sb[7:0]), .n_terms(nt),
        .out_ready(rdy), .out_valid(vs), .out_data(ds),
        .out_idx(is_), .out_ovf(os), .busy(bs),
        .done(dns), .ovf(fs)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: WIDTH+1-bit sums with a sticky wrap flag
    task automatic push_exp(input int which, input logic [31:0] a,
                            input logic [31:0] b, input int n);
        longint unsigned mask, p1, p2, s, t;
        bit f1, f2, f;
        int w;
        exp_t e;
        w = (which == 0) ? 32 : 8;
        mask = (64'd1 << w) - 64'd1;
        p2 = 0; p1 = 0; f1 = 0; f2 = 0;
        for (int i = 0; i < n; i++) begin
            if (i == 0) begin
                t = a & mask; f = 0;
            end else if (i == 1) begin
                t = b & mask; f = 0;
            end else begin
                s = p1 + p2;
                f = (s > mask) | f1 | f2;
                t = s & mask;
            end
            if (which == 2 && f) break;
            e.d = t[31:0];
            e.i = i[7:0];
            e.o = f;
            case (which)
                0: q32.push_back(e);
                1: qw.push_back(e);
                default: qs.push_back(e);
            endcase
            p2 = p1; f2 = f1;
            p1 = t;  f1 = f;
        end
    endtask

    function automatic int qsize(input int which);
        case (which)
            0: return q32.size();
            1: return qw.size();
            default: return qs.size();
        endcase
    endfunction

    always @(posedge clk) begin
        #1;
        if (rnd_en) rdy = 1'($urandom_range(0, 1));
    end

    logic        l_v = 1'b0;
    logic        l_r = 1'b0;
    logic [31:0] l_d = '0;
    logic [7:0]  l_i = '0;
    exp_t        e32, ew, es;

    always @(negedge clk) begin
        if (v32 && rdy) begin
            if (q32.size() == 0) check("u32_extra", 1, 0);
            else begin
                e32 = q32.pop_front();
                check("u32_data", d32, e32.d);
                check("u32_idx", i32, e32.i);
                check("u32_ovf", o32, e32.o);
            end
        end
        if (l_v && !l_r && v32) begin
            check("stall_data", d32, l_d);
            check("stall_idx", i32, l_i);
        end
        l_v = v32; l_r = rdy; l_d = d32; l_i = i32;
    end

    always @(negedge clk) begin
        if (vw && rdy) begin
            if (qw.size() == 0) check("u8w_extra", 1, 0);
            else begin
                ew = qw.pop_front();
                check("u8w_data", {24'h0, dw}, ew.d);
                check("u8w_idx", iw, ew.i);
                check("u8w_ovf", ow, ew.o);
            end
        end
    end

    always @(negedge clk) begin
        if (vs && os) check("u8s_flagged", 1, 0);
        if (vs && rdy) begin
            if (qs.size() == 0) check("u8s_extra", 1, 0);
            else begin
                es = qs.pop_front();
                check("u8s_data", {24'h0, ds}, es.d);
                check("u8s_idx", is_, es.i);
            end
        end
    end

    task automatic run(input int which, input logic [31:0] a,
                       input logic [31:0] b, input int n,
                       input bit exp_ovf, input int poke);
        bit seen;
        push_exp(which, a, b, n);
        @(negedge clk);
        sa = a; sb = b; nt = n[7:0];
        st[which] = 1'b1;
        @(negedge clk);
        st[which] = 1'b0;
        check("lat_valid", vl[which], n > 0);
        seen = 0;
        for (int c = 0; c < 400; c++) begin
            if (poke > 0 && c == poke) begin
                sa = 32'd100; sb = 32'd100; nt = 8'd3;
                st[which] = 1'b1;
            end else begin
                st[which] = 1'b0;
            end
            if (dn[which]) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        st[which] = 1'b0;
        check("done_seen", seen, 1);
        check("busy_in_done", bz[which], 1);
        check("valid_in_done", vl[which], 0);
        check("q_empty", qsize(which), 0);
        check("ovf_sticky", ov[which], exp_ovf);
        @(negedge clk);
        check("done_low", dn[which], 0);
        check("idle_busy", bz[which], 0);
        check("ovf_held", ov[which], exp_ovf);
    endtask

    initial begin
        bit hit;
        repeat (3) @(negedge clk);
        check("rst_valid", v32, 0);
        check("rst_data", d32, 0);
        check("rst_idx", i32, 0);
        check("rst_busy", {bs, bw, b32}, 0);
        check("rst_done", {dns, dnw, dn32}, 0);
        check("rst_ovf", {fs, fw, f32, o32}, 0);
        st = 3'b111;
        @(negedge clk);
        st = '0;
        rst = 1'b0;
        check("start_with_rst", {bs, bw, b32}, 0);

        run(0, 32'd0, 32'd1, 10, 0, 0);
        run(1, 32'd0, 32'd1, 16, 1, 0);
        run(2, 32'd0, 32'd1, 16, 1, 0);

        rnd_en = 1'b1;
        run(0, 32'd2, 32'd3, 5, 0, 0);
        run(0, 32'hFFFF_FFF0, 32'h10, 6, 1, 0);
        @(negedge clk);
        rnd_en = 1'b0;
        rdy = 1'b1;

        run(0, 32'd0, 32'd0, 0, 0, 0);
        run(0, 32'd1, 32'd2, 6, 0, 2);

        push_exp(0, 32'd0, 32'd1, 10);
        @(negedge clk);
        sa = 0; sb = 1; nt = 8'd10;
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        hit = 0;
        for (int c = 0; c < 50; c++) begin
            if (v32 && i32 == 8'd4) begin
                hit = 1;
                break;
            end
            @(negedge clk);
        end
        check("reach_idx4", hit, 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", v32, 0);
        check("mid_rst_busy", b32, 0);
        check("mid_rst_ovf", f32, 0);
        check("mid_rst_idx", i32, 0);
        rst = 1'b0;
        q32.delete();
        run(0, 32'd5, 32'd5, 4, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
